// File: rtl/truth_table_checker.sv
// Exhaustive 3-input truth-table checker: walks {a,b,c} through 0..7,
// waits SETTLE cycles per vector, then compares f against EXPECTED.
module truth_table_checker #(
    parameter logic [7:0] EXPECTED = 8'b1001_0110,
    parameter int         SETTLE   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       f,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_count,
    output logic [2:0] first_fail_idx
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] settle_q, settle_d;
    logic [3:0] fail_count_q, fail_count_d;
    logic [2:0] first_fail_idx_q, first_fail_idx_d;
    logic       pass_q, pass_d;
    logic       mismatch;

    assign mismatch = (state_q == SAMPLE) && (f != EXPECTED[idx_q]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            idx_q            <= 3'd0;
            settle_q         <= 4'd0;
            fail_count_q     <= 4'd0;
            first_fail_idx_q <= 3'd0;
            pass_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            settle_q         <= settle_d;
            fail_count_q     <= fail_count_d;
            first_fail_idx_q <= first_fail_idx_d;
            pass_q           <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = DRIVE;
            DRIVE:   if (settle_q == SETTLE_LAST) state_d = SAMPLE;
            SAMPLE:  state_d = (idx_q == 3'd7) ? DONE : DRIVE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idx_d            = idx_q;
        settle_d         = settle_q;
        fail_count_d     = fail_count_q;
        first_fail_idx_d = first_fail_idx_q;
        pass_d           = pass_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d            = 3'd0;
                    settle_d         = 4'd0;
                    fail_count_d     = 4'd0;
                    first_fail_idx_d = 3'd0;
                    pass_d           = 1'b0;
                end
            end
            DRIVE: begin
                if (settle_q != SETTLE_LAST) settle_d = settle_q + 4'd1;
            end
            SAMPLE: begin
                if (mismatch) begin
                    if (fail_count_q != 4'd8) fail_count_d = fail_count_q + 4'd1;
                    if (fail_count_q == 4'd0) first_fail_idx_d = idx_q;
                end
                // pass must already reflect the final sample in the DONE cycle
                if (idx_q == 3'd7) begin
                    pass_d = (fail_count_d == 4'd0);
                end else begin
                    idx_d    = idx_q + 3'd1;
                    settle_d = 4'd0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy           = (state_q == DRIVE) || (state_q == SAMPLE);
        done           = (state_q == DONE);
        {a, b, c}      = idx_q;
        pass           = pass_q;
        fail_count     = fail_count_q;
        first_fail_idx = first_fail_idx_q;
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker: default XOR table plus an
// all-zero table instance, with behavioural f models for each scenario.
module tb_truth_table_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       start_z = 1'b0;
    int         mode = 0;
    logic       f, a, b, c, busy, done, pass;
    logic [3:0] fail_count;
    logic [2:0] first_fail_idx;
    logic       f_z, a_z, b_z, c_z, busy_z, done_z, pass_z;
    logic [3:0] fail_count_z;
    logic [2:0] first_fail_idx_z;

    int         checks = 0;
    int         errors = 0;
    logic       busy_log [0:63];
    logic [2:0] abc_log  [0:63];

    always #5 clk = ~clk;

    function automatic logic model(input int m, input logic [2:0] i);
        case (m)
            0:       return ^i;
            1:       return (^i) ^ (i == 3'd5);
            2:       return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    assign f   = model(mode, {a, b, c});
    assign f_z = model(mode, {a_z, b_z, c_z});

    truth_table_checker u_dut (
        .clk(clk), .rst(rst), .start(start), .f(f),
        .a(a), .b(b), .c(c), .busy(busy), .done(done), .pass(pass),
        .fail_count(fail_count), .first_fail_idx(first_fail_idx)
    );

    truth_table_checker #(.EXPECTED(8'h00), .SETTLE(2)) u_dut_z (
        .clk(clk), .rst(rst), .start(start_z), .f(f_z),
        .a(a_z), .b(b_z), .c(c_z), .busy(busy_z), .done(done_z),
        .pass(pass_z), .fail_count(fail_count_z),
        .first_fail_idx(first_fail_idx_z)
    );

    task automatic do_run(input bit use_z, input bit hold,
                          output int done_cyc, output int n_done);
        done_cyc = -1;
        n_done   = 0;
        @(posedge clk); #1;
        if (use_z) start_z = 1'b1; else start = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            if (!hold) begin
                start   = 1'b0;
                start_z = 1'b0;
            end
            @(negedge clk);
            busy_log[cyc] = use_z ? busy_z : busy;
            abc_log[cyc]  = use_z ? {a_z, b_z, c_z} : {a, b, c};
            if (use_z ? done_z : done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
        end
        start   = 1'b0;
        start_z = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, pass, fail_count, first_fail_idx, a, b, c} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 0",
                     {busy, done, pass, fail_count, first_fail_idx, a, b, c});
        end
        checks++;
        if ({busy_z, done_z, pass_z, fail_count_z} !== 7'd0) begin
            errors++;
            $display("FAIL reset_outputs_z: got %b want 0",
                     {busy_z, done_z, pass_z, fail_count_z});
        end
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_priority: busy=%b want 0", busy);
        end
    endtask

    task automatic test_xor_pass();
        int dc, nd;
        mode = 0;
        do_run(1'b0, 1'b0, dc, nd);
        checks++;
        if (dc !== 25) begin
            errors++;
            $display("FAIL xor_latency: done at %0d want 25", dc);
        end
        checks++;
        if (nd !== 1) begin
            errors++;
            $display("FAIL xor_done_count: %0d want 1", nd);
        end
        checks++;
        if ({pass, fail_count, first_fail_idx} !== {1'b1, 4'd0, 3'd0}) begin
            errors++;
            $display("FAIL xor_result: pass=%b fc=%0d ffi=%0d want 1 0 0",
                     pass, fail_count, first_fail_idx);
        end
        checks++;
        if ({abc_log[1], abc_log[3], abc_log[4], abc_log[24], abc_log[25]}
            !== {3'd0, 3'd0, 3'd1, 3'd7, 3'd7}) begin
            errors++;
            $display("FAIL xor_abc_seq: %0d %0d %0d %0d %0d want 0 0 1 7 7",
                     abc_log[1], abc_log[3], abc_log[4], abc_log[24], abc_log[25]);
        end
        checks++;
        if ({busy_log[1], busy_log[24], busy_log[25]} !== 3'b110) begin
            errors++;
            $display("FAIL xor_busy: %b%b%b want 110",
                     busy_log[1], busy_log[24], busy_log[25]);
        end
    endtask

    task automatic test_single_fault();
        int dc, nd;
        mode = 1;
        do_run(1'b0, 1'b0, dc, nd);
        checks++;
        if ({pass, fail_count, first_fail_idx} !== {1'b0, 4'd1, 3'd5}) begin
            errors++;
            $display("FAIL single_fault: pass=%b fc=%0d ffi=%0d want 0 1 5",
                     pass, fail_count, first_fail_idx);
        end
        repeat (5) @(negedge clk);
        checks++;
        if ({pass, fail_count, first_fail_idx} !== {1'b0, 4'd1, 3'd5}) begin
            errors++;
            $display("FAIL idle_hold: pass=%b fc=%0d ffi=%0d want 0 1 5",
                     pass, fail_count, first_fail_idx);
        end
    endtask

    task automatic test_stuck0();
        int dc, nd;
        mode = 2;
        do_run(1'b0, 1'b0, dc, nd);
        checks++;
        if ({pass, fail_count, first_fail_idx} !== {1'b0, 4'd4, 3'd1}) begin
            errors++;
            $display("FAIL stuck0: pass=%b fc=%0d ffi=%0d want 0 4 1",
                     pass, fail_count, first_fail_idx);
        end
    endtask

    task automatic test_expected_zero();
        int dc, nd;
        mode = 3;
        do_run(1'b1, 1'b0, dc, nd);
        checks++;
        if (dc !== 25) begin
            errors++;
            $display("FAIL zero_latency: done at %0d want 25", dc);
        end
        checks++;
        if ({pass_z, fail_count_z, first_fail_idx_z} !== {1'b0, 4'd8, 3'd0}) begin
            errors++;
            $display("FAIL zero_saturate: pass=%b fc=%0d ffi=%0d want 0 8 0",
                     pass_z, fail_count_z, first_fail_idx_z);
        end
    endtask

    task automatic test_start_held();
        int dc, nd;
        mode = 0;
        do_run(1'b0, 1'b1, dc, nd);
        checks++;
        if (dc !== 25 || nd !== 1) begin
            errors++;
            $display("FAIL held_done: first=%0d count=%0d want 25 1", dc, nd);
        end
        checks++;
        if ({busy_log[26], busy_log[27]} !== 2'b01) begin
            errors++;
            $display("FAIL held_restart: busy26/27=%b%b want 01",
                     busy_log[26], busy_log[27]);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset_abort();
        int dc, nd;
        nd   = 0;
        mode = 2;
        @(posedge clk); #1;
        start = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (cyc == 10) rst = 1'b1;
            if (cyc == 11) rst = 1'b0;
            @(negedge clk);
            if (done) nd++;
            if (cyc == 10) begin
                checks++;
                if (fail_count !== 4'd2 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL abort_pre: fc=%0d busy=%b want 2 1",
                             fail_count, busy);
                end
            end
            if (cyc == 11) begin
                checks++;
                if ({busy, done, pass, fail_count, first_fail_idx, a, b, c} !== 13'd0) begin
                    errors++;
                    $display("FAIL abort_clear: got %b want 0",
                             {busy, done, pass, fail_count, first_fail_idx, a, b, c});
                end
            end
        end
        checks++;
        if (nd !== 0) begin
            errors++;
            $display("FAIL abort_no_done: %0d pulses want 0", nd);
        end
        mode = 0;
        do_run(1'b0, 1'b0, dc, nd);
        checks++;
        if (dc !== 25 || pass !== 1'b1 || fail_count !== 4'd0) begin
            errors++;
            $display("FAIL abort_rerun: done=%0d pass=%b fc=%0d want 25 1 0",
                     dc, pass, fail_count);
        end
    endtask

    initial begin
        test_reset();
        test_xor_pass();
        test_single_fault();
        test_stuck0();
        test_expected_zero();
        test_start_held();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/truth_table_checker.md
TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

Interface
REQ-001 Parameter EXPECTED, default 8'b1001_0110, gives the expected output for each input vector: bit i is the expected f for {a,b,c}=i.
REQ-002 Parameter SETTLE, default 2, is the number of drive cycles before sampling; legal range 1..15.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  request one full exhaustive check; sampled only in IDLE.
REQ-007 f  input  1  response of the component under test.
REQ-008 a  output  1  stimulus MSB (idx[2]).
REQ-009 b  output  1  stimulus (idx[1]).
REQ-010 c  output  1  stimulus LSB (idx[0]).
REQ-011 busy  output  1  high while in DRIVE or SAMPLE.
REQ-012 done  output  1  one-cycle pulse when a run completes.
REQ-013 pass  output  1  high when the last completed run had zero mismatches.
REQ-014 fail_count  output  4  number of mismatches in the current or last run (0..8).
REQ-015 first_fail_idx  output  3  input index of the first mismatch; 0 if there was none.

Function
REQ-016 The FSM SHALL have states IDLE, DRIVE, SAMPLE and DONE, all registered.
REQ-017 IDLE -> DRIVE on start=1: clear idx, settle_cnt, fail_count and first_fail_idx; clear pass.
REQ-018 {a,b,c} SHALL equal idx in every state, and 3'b000 in IDLE after reset.
REQ-019 DRIVE SHALL last exactly SETTLE cycles, with settle_cnt counting 0..SETTLE-1, then go to SAMPLE.
REQ-020 SAMPLE SHALL last one cycle and compare f with EXPECTED[idx] in that cycle.
REQ-021 On a mismatch, fail_count SHALL increment, saturating at 8.
REQ-022 On the first mismatch of a run only, first_fail_idx SHALL load idx.
REQ-023 From SAMPLE: if idx!=7, increment idx, clear settle_cnt and go to DRIVE; if idx==7, go to DONE with no wrap to 0 inside the run.
REQ-024 DONE SHALL last one cycle with done=1 and pass=(fail_count==0 including the final sample), then go to IDLE unconditionally.
REQ-025 start SHALL be ignored in DRIVE, SAMPLE and DONE; no queuing.
REQ-026 Latency: with start high at cycle 0, done SHALL be high at cycle 1+8*(SETTLE+1), which is cycle 25 for SETTLE=2.
REQ-027 pass, fail_count and first_fail_idx SHALL hold their values in IDLE until the next accepted start.
REQ-028 busy SHALL be a decode of the state only, with no combinational path from start.

Reset
REQ-029 rst=1 SHALL force IDLE with idx=0, settle_cnt=0, a=b=c=0, busy=0, done=0, pass=0, fail_count=0 and first_fail_idx=0.
REQ-030 rst SHALL take priority over start in the same cycle.
REQ-031 rst during a run SHALL abort it: no done pulse, and results are cleared.

Verification
REQ-032 EXPECTED=8'h96 (3-input XOR), DUT model f=a^b^c, pulse start -> done at cycle 25, pass=1, fail_count=0, first_fail_idx=0.
REQ-033 Same EXPECTED, model f inverted only at idx 5 -> pass=0, fail_count=1, first_fail_idx=5.
REQ-034 Same EXPECTED, f stuck at 0 -> fail_count=4, first_fail_idx=1, pass=0.
REQ-035 EXPECTED=8'h00, f stuck at 1 -> fail_count=8 (saturated), first_fail_idx=0, pass=0.
REQ-036 start held high during a whole run -> exactly one done pulse at cycle 25; the next run starts only after returning to IDLE.
REQ-037 rst asserted at cycle 10 of a run -> next cycle IDLE with all outputs 0; no done pulse; a fresh start then completes normally.
